// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the fetch stage.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          PC_STEP   = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Fetch program counter: word-aligned load with priority over a wrapping increment.
module pc_reg
  import riscv_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pc,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  // Masking the low bits keeps every fetch address word aligned.
  // The increment wraps naturally modulo 2^WIDTH.
  always_ff @(posedge clk) begin
    if (rst)       pc <= WIDTH'(RESET_PC);
    else if (load) pc <= load_pc & ~WIDTH'(3);
    else if (inc)  pc <= pc + WIDTH'(PC_STEP);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues req/ack word fetches,
// and holds the fetched word in an instruction register until consumed.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] opcode,
  output logic [WIDTH-1:0] pc,
  output logic             valid
);

  fetch_state_t     state;
  logic [WIDTH-1:0] fetch_pc;
  logic             fetch_done;

  // A completed transfer only counts in REQ and never alongside a redirect,
  // so an ack racing a redirect cannot advance the PC.
  assign fetch_done = (state == REQ) && imem_ack && !redirect;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect),
    .load_pc (redirect_pc),
    .inc     (fetch_done),
    .pc      (fetch_pc)
  );

  // Request and address are decoded straight from registered state.
  assign imem_req  = (state == REQ);
  assign imem_addr = fetch_pc;

  // Fetch FSM and instruction register; reset beats redirect beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opcode <= WIDTH'(NOP_INSTR);
      pc     <= WIDTH'(RESET_PC);
      valid  <= 1'b0;
    end else if (redirect) begin
      state  <= REQ;
      opcode <= WIDTH'(NOP_INSTR);
      valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ack) begin
            opcode <= imem_rdata;
            pc     <= fetch_pc;
            valid  <= 1'b1;
            state  <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            valid <= 1'b0;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] opcode;
  logic [31:0] pc;
  logic        valid;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .opcode      (opcode),
    .pc          (pc),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    step(); step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", valid); end
    checks++; if (opcode !== NOP) begin errors++; $display("FAIL rst_opcode got %08h want %08h", opcode, NOP); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %08h want 0", pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %08h want 0", imem_addr); end
    rst = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %0h want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %08h want 0", imem_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_valid got %0h want 0", valid); end
  endtask

  task automatic test_zero_wait();
    imem_ack = 1'b1; imem_rdata = 32'h0080_0293;
    step();
    checks++; if (opcode !== 32'h0080_0293) begin errors++; $display("FAIL zw_opcode got %08h want 00800293", opcode); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL zw_pc got %08h want 0", pc); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL zw_valid got %0h want 1", valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_req got %0h want 0", imem_req); end
    imem_ack = 1'b0; stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_next_req got %0h want 1", imem_req); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL zw_next_addr got %08h want 4", imem_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zw_consumed got %0h want 0", valid); end
  endtask

  task automatic test_wait_states();
    imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL ws_addr[%0d] got %08h want 4", i, imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ws_req[%0d] got %0h want 1", i, imem_req); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ws_valid[%0d] got %0h want 0", i, valid); end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0010_0093;
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ws_ack_valid got %0h want 1", valid); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL ws_pc got %08h want 4", pc); end
    checks++; if (opcode !== 32'h0010_0093) begin errors++; $display("FAIL ws_opcode got %08h want 00100093", opcode); end
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;  // ack outside REQ must be ignored
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (opcode !== 32'h0010_0093) begin errors++; $display("FAIL st_opcode[%0d] got %08h want 00100093", i, opcode); end
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL st_pc[%0d] got %08h want 4", i, pc); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL st_valid[%0d] got %0h want 1", i, valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req[%0d] got %0h want 0", i, imem_req); end
    end
    stall = 1'b0; imem_ack = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL st_rel_req got %0h want 1", imem_req); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL st_rel_addr got %08h want 8", imem_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL st_rel_valid got %0h want 0", valid); end
  endtask

  task automatic test_redirect();
    // In REQ at 8: redirect and ack collide, the ack must be thrown away.
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rd_valid got %0h want 0", valid); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rd_addr got %08h want 100", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_req got %0h want 1", imem_req); end
    checks++; if (opcode !== NOP) begin errors++; $display("FAIL rd_opcode got %08h want %08h", opcode, NOP); end
    redirect = 1'b0; imem_ack = 1'b0;
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rd_hold_valid got %0h want 0", valid); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rd_hold_addr got %08h want 100", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0020_0113;
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rd_new_valid got %0h want 1", valid); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rd_new_pc got %08h want 100", pc); end
    checks++; if (opcode !== 32'h0020_0113) begin errors++; $display("FAIL rd_new_opcode got %08h want 00200113", opcode); end
    imem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Sitting in VALID at pc 0x100 with stall held; reset must win.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0400;
    rst = 1'b1;
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %0h want 0", valid); end
    checks++; if (opcode !== NOP) begin errors++; $display("FAIL rm_opcode got %08h want %08h", opcode, NOP); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req got %0h want 0", imem_req); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rm_pc got %08h want 0", pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr got %08h want 0", imem_addr); end
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_restart_req got %0h want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_restart_addr got %08h want 0", imem_addr); end
  endtask

  task automatic test_wrap();
    // Unaligned target also checks that the low address bits are cleared.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr got %08h want fffffffc", imem_addr); end
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0030_0193;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc got %08h want fffffffc", pc); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wr_valid got %0h want 1", valid); end
    imem_ack = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wr_next_addr got %08h want 0", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wr_next_req got %0h want 1", imem_req); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
